// File: rtl/vid_pkg.sv
// vid_pkg: shared state type, geometry defaults and widths for the video-input
// position recovery block.
package vid_pkg;

    localparam int COORD_W   = 11;
    localparam int LINES_W   = 12;
    localparam int GOOD_W    = 4;
    localparam int DEF_X_MAX = 1920;
    localparam int DEF_Y_MAX = 1080;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        BLANK  = 2'd1,
        LINE   = 2'd2
    } vid_state_t;

    // Increment that sticks at lim instead of running past it.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/vid_edge_det.sv
// vid_edge_det: keeps the previous sample of a timing input and flags its
// rising and falling edges against the current sample.
module vid_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset)
            d_q <= 1'b0;
        else
            d_q <= d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/vid_pos_recover.sv
// vid_pos_recover: rebuilds the (x, y) scan position from a de/vsync stream and
// tracks geometry lock. Define VID_POS_STATS_EN to add meas_w/meas_h outputs.
module vid_pos_recover
    import vid_pkg::*;
#(
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               de,
    input  logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pos_valid,
    output logic               line_end,
    output logic               frame_start,
    output logic               locked,
    output logic               err
`ifdef VID_POS_STATS_EN
    ,
    output logic [LINES_W-1:0] meas_w,
    output logic [LINES_W-1:0] meas_h
`endif
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_MAX - 1);
    localparam logic [LINES_W-1:0] Y_LINES  = LINES_W'(Y_MAX);
    localparam logic [GOOD_W-1:0]  LOCK_CNT = GOOD_W'(LOCK_FRAMES);

    vid_state_t         state, state_nxt;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               pv_nxt, le_nxt, fs_nxt, err_nxt, locked_nxt;
    logic [GOOD_W-1:0]  good_cnt, good_nxt;
    logic [LINES_W-1:0] lines_seen, lines_nxt;
    logic               frame_good;
    logic               de_rise, de_fall, vs_rise, vs_fall;

    vid_edge_det u_de_edge (
        .clk   (clk),
        .reset (reset),
        .d     (de),
        .rise  (de_rise),
        .fall  (de_fall)
    );

    vid_edge_det u_vs_edge (
        .clk   (clk),
        .reset (reset),
        .d     (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    // vsync falling edges carry no information for position recovery.
    logic unused_vs_fall;
    assign unused_vs_fall = vs_fall;

    always_comb begin
        // NOTE: every value gets a default first so no branch can infer a latch.
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        pv_nxt     = 1'b0;
        le_nxt     = 1'b0;
        fs_nxt     = 1'b0;
        err_nxt    = err;
        good_nxt   = good_cnt;
        locked_nxt = locked;
        lines_nxt  = lines_seen;

        // A frame closed straight out of SEARCH was never fully observed.
        frame_good = (state != SEARCH) && !err && (lines_seen == Y_LINES);

        if (vs_rise) begin
            state_nxt = BLANK;
            fs_nxt    = 1'b1;
            y_nxt     = '0;
            lines_nxt = '0;
            err_nxt   = de && (state != SEARCH);
            if (frame_good)
                good_nxt = (good_cnt >= LOCK_CNT) ? LOCK_CNT : good_cnt + 1'b1;
            else
                good_nxt = '0;
            locked_nxt = (good_nxt >= LOCK_CNT);
        end else begin
            case (state)
                SEARCH: begin
                    state_nxt = SEARCH;
                end
                BLANK: begin
                    // Only a fresh rise starts a line; a de held across vsync does not.
                    if (de_rise) begin
                        state_nxt = LINE;
                        x_nxt     = '0;
                        pv_nxt    = 1'b1;
                    end
                end
                LINE: begin
                    if (de_fall) begin
                        state_nxt = BLANK;
                        le_nxt    = 1'b1;
                        y_nxt     = sat_inc(y, Y_LAST);
                        lines_nxt = (lines_seen == '1) ? lines_seen : lines_seen + 1'b1;
                        if ((x != X_LAST) || (lines_seen >= Y_LINES))
                            err_nxt = 1'b1;
                    end else if (de) begin
                        pv_nxt = 1'b1;
                        if (x >= X_LAST)
                            err_nxt = 1'b1;
                        else
                            x_nxt = x + 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state       <= SEARCH;
            x           <= '0;
            y           <= '0;
            pos_valid   <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
            lines_seen  <= '0;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            pos_valid   <= pv_nxt;
            line_end    <= le_nxt;
            frame_start <= fs_nxt;
            err         <= err_nxt;
            locked      <= locked_nxt;
            good_cnt    <= good_nxt;
            lines_seen  <= lines_nxt;
        end
    end

`ifdef VID_POS_STATS_EN
    logic [LINES_W-1:0] len_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_cnt <= '0;
            meas_w  <= '0;
            meas_h  <= '0;
        end else begin
            if (pv_nxt)
                len_cnt <= (state == LINE) ? ((len_cnt == '1) ? len_cnt : len_cnt + 1'b1)
                                           : LINES_W'(1);
            if (le_nxt)
                meas_w <= len_cnt;
            if (fs_nxt)
                meas_h <= lines_seen;
        end
    end
`else
    // Without the statistics option no width/height measurement is kept.
`endif

endmodule
